// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared encodings and lane helpers for the sized data memory
package data_mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   // An all-zero result doubles as the misalignment indication.
   function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] addr);
      logic [3:0] be;
      be = 4'b0000;
      case (size)
         SZ_BYTE: be = 4'b0001 << addr;
         SZ_HALF: be = addr[0] ? 4'b0000 : (4'b0011 << addr);
         SZ_WORD: be = (addr == 2'b00) ? 4'b1111 : 4'b0000;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] addr, input logic is_unsigned);
      logic [31:0] shifted;
      logic [31:0] result;
      shifted = word >> {addr, 3'b000};
      case (size)
         SZ_BYTE: result = is_unsigned ? {24'h000000, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
         SZ_HALF: result = is_unsigned ? {16'h0000, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
         default: result = word;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/data_mem_array.sv
// rtl/data_mem_array.sv - word array with byte-enable write and combinational read
// Parity storage present only with DATA_MEMORY_SIZED_PARITY_EN.
module data_mem_array #(
   parameter int DEPTH = 1024,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_we,
   input  logic [IDX_W-1:0] i_idx,
   input  logic [3:0]       i_be,
   input  logic [31:0]      i_wdata,
   output logic [31:0]      o_rdata,
   output logic [3:0]       o_par_err
);

   logic [31:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         for (int b = 0; b < 4; b++) begin
            if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
         end
      end
   end

   assign o_rdata = r_mem[i_idx];

`ifdef DATA_MEMORY_SIZED_PARITY_EN
   logic [3:0] r_par [DEPTH];

   // Even parity per lane, stored alongside the data byte it covers.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         for (int b = 0; b < 4; b++) begin
            if (i_be[b]) r_par[i_idx][b] <= ^i_wdata[8*b +: 8];
         end
      end
   end

   always_comb begin
      o_par_err = 4'b0000;
      for (int b = 0; b < 4; b++) begin
         o_par_err[b] = r_par[i_idx][b] ^ (^r_mem[i_idx][8*b +: 8]);
      end
   end
`else
   assign o_par_err = 4'b0000;
`endif

endmodule

// File: rtl/data_memory_sized.sv
// rtl/data_memory_sized.sv - MEM-stage data memory with sized access, alignment check, wait states
// Optional per-lane parity: define DATA_MEMORY_SIZED_PARITY_EN.
module data_memory_sized
   import data_mem_pkg::*;
#(
   parameter int DEPTH       = 1024,
   parameter int ADDR_W      = 32,
   parameter int WAIT_STATES = 0
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Req,
   input  logic              MemWrite,
   input  logic              MemRead,
   input  logic [ADDR_W-1:0] Address,
   input  logic [31:0]       WriteData,
   input  logic [1:0]        Size,
   input  logic              Unsigned,
   output logic [31:0]       ReadData,
   output logic              Ready,
   output logic              Misaligned,
   output logic              ParityErr
);

   localparam int         IDX_W = $clog2(DEPTH);
   localparam logic [3:0] WS    = 4'(WAIT_STATES);

   state_t           r_state, w_next;
   logic [3:0]       r_cnt;
   logic             r_write;
   logic [IDX_W+1:0] r_addr;
   logic [1:0]       r_size;
   logic             r_unsigned;
   logic [31:0]      r_wdata;

   logic             w_accept, w_done, w_misaligned, w_we;
   logic [3:0]       w_be, w_par_err;
   logic [31:0]      w_rdata, w_lane_data;
   logic             w_unused_addr;

   // Bits above the word index only alias the array, so they are dropped.
   assign w_unused_addr = ^Address[ADDR_W-1:IDX_W+2];

   assign w_accept     = (r_state == ST_IDLE) && Req && (MemRead ^ MemWrite);
   assign w_done       = (r_state == ST_DONE);
   assign w_be         = byte_enables(r_size, r_addr[1:0]);
   assign w_misaligned = (w_be == 4'b0000);
   assign w_we         = w_done && r_write && !w_misaligned;
   assign w_lane_data  = r_wdata << {r_addr[1:0], 3'b000};

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_next = (WS == 4'd0) ? ST_DONE : ST_WAIT;
         ST_WAIT: if (r_cnt <= 4'd1) w_next = ST_DONE;
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_next;
         if (w_accept)                r_cnt <= WS;
         else if (r_state == ST_WAIT) r_cnt <= r_cnt - 4'd1;
      end
   end

   always_ff @(posedge Clk) begin
      if (w_accept) begin
         r_write    <= MemWrite;
         r_addr     <= Address[IDX_W+1:0];
         r_size     <= Size;
         r_unsigned <= Unsigned;
         r_wdata    <= WriteData;
      end
   end

   data_mem_array #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_array (
      .i_clk     (Clk),
      .i_we      (w_we),
      .i_idx     (r_addr[IDX_W+1:2]),
      .i_be      (w_be),
      .i_wdata   (w_lane_data),
      .o_rdata   (w_rdata),
      .o_par_err (w_par_err)
   );

   // ReadData is only touched by reads, so it survives intervening stores.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         Ready      <= 1'b0;
         ReadData   <= 32'h0;
         Misaligned <= 1'b0;
         ParityErr  <= 1'b0;
      end else begin
         Ready      <= w_done;
         Misaligned <= w_done && w_misaligned;
         ParityErr  <= w_done && !r_write && !w_misaligned && (|(w_par_err & w_be));
         if (w_done && !r_write)
            ReadData <= w_misaligned ? 32'h0
                                     : load_extract(w_rdata, r_size, r_addr[1:0], r_unsigned);
      end
   end

endmodule

// File: tb/tb_data_memory_sized.sv
// tb/tb_data_memory_sized.sv - directed bench: DEPTH=16/WS=0 and DEPTH=64/WS=3 instances side by side
module tb_data_memory_sized;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0 = 1'b0, req3 = 1'b0;
   logic        mem_write = 1'b0, mem_read = 1'b0;
   logic [31:0] address = 32'h0, write_data = 32'h0;
   logic [1:0]  size = 2'b10;
   logic        uns = 1'b0;

   logic [31:0] o0_rdata, o3_rdata;
   logic        o0_ready, o3_ready, o0_mis, o3_mis, o0_perr, o3_perr;

   int n_vec = 0, n_err = 0;
   int lat0, lat3, cnt0, cnt3;
   logic [31:0] rd0, rd3;
   logic mis0, mis3, pe0, pe3;

   always #5 clk = ~clk;

   data_memory_sized #(.DEPTH(16), .ADDR_W(32), .WAIT_STATES(0)) u_dut0 (
      .Clk(clk), .Reset(rst_n), .Req(req0), .MemWrite(mem_write), .MemRead(mem_read),
      .Address(address), .WriteData(write_data), .Size(size), .Unsigned(uns),
      .ReadData(o0_rdata), .Ready(o0_ready), .Misaligned(o0_mis), .ParityErr(o0_perr));

   data_memory_sized #(.DEPTH(64), .ADDR_W(32), .WAIT_STATES(3)) u_dut3 (
      .Clk(clk), .Reset(rst_n), .Req(req3), .MemWrite(mem_write), .MemRead(mem_read),
      .Address(address), .WriteData(write_data), .Size(size), .Unsigned(uns),
      .ReadData(o3_rdata), .Ready(o3_ready), .Misaligned(o3_mis), .ParityErr(o3_perr));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One request to both instances, then an 8-cycle observation window.
   task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [1:0] sz, input logic un,
                         input bit stray, input int rst_at);
      @(negedge clk);
      mem_read = rd; mem_write = wr; address = addr; write_data = wd; size = sz; uns = un;
      req0 = 1'b1; req3 = 1'b1;
      @(posedge clk); #1;
      req0 = 1'b0; req3 = 1'b0;
      mem_read = 1'b0; mem_write = 1'b1; address = $urandom; write_data = $urandom;
      size = 2'($urandom); uns = ~un;
      lat0 = -1; lat3 = -1; cnt0 = 0; cnt3 = 0;
      rd0 = 'x; rd3 = 'x; mis0 = 1'bx; mis3 = 1'bx; pe0 = 1'bx; pe3 = 1'bx;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk); #1;
         if (o0_ready === 1'b1) begin
            cnt0++;
            if (lat0 < 0) begin lat0 = c; rd0 = o0_rdata; mis0 = o0_mis; pe0 = o0_perr; end
         end
         if (o3_ready === 1'b1) begin
            cnt3++;
            if (lat3 < 0) begin lat3 = c; rd3 = o3_rdata; mis3 = o3_mis; pe3 = o3_perr; end
         end
         if (stray && c == 2) begin req3 = 1'b1; mem_read = 1'b1; mem_write = 1'b0; end
         if (stray && c == 4) req3 = 1'b0;
         if (c == rst_at) begin rst_n = 1'b0; #2; rst_n = 1'b1; end
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready0", {31'h0, o0_ready}, 32'h0);
      check("rst_rdata0", o0_rdata, 32'h0);
      check("rst_mis0", {31'h0, o0_mis}, 32'h0);
      check("rst_perr0", {31'h0, o0_perr}, 32'h0);
      check("rst_ready3", {31'h0, o3_ready}, 32'h0);
      check("rst_rdata3", o3_rdata, 32'h0);
      @(negedge clk); rst_n = 1'b1;

      access(0, 1, 32'h0, 32'h12345678, 2'b10, 0, 0, 0);
      check("wr0_lat0", lat0, 1);
      check("wr0_lat3", lat3, 4);
      check("wr0_mis0", {31'h0, mis0}, 32'h0);
      access(1, 0, 32'h0, 32'h0, 2'b10, 0, 0, 0);
      check("rd0_lat0", lat0, 1);
      check("rd0_cnt0", cnt0, 1);
      check("rd0_data0", rd0, 32'h12345678);
      check("rd0_data3", rd3, 32'h12345678);
      check("rd0_mis0", {31'h0, mis0}, 32'h0);
      check("rd0_perr0", {31'h0, pe0}, 32'h0);
      check("rd0_hold0", o0_rdata, 32'h12345678);

      access(0, 1, 32'h4, 32'hABCDEF00, 2'b10, 0, 0, 0);
      access(0, 1, 32'h5, 32'hFFFFFF98, 2'b00, 0, 0, 0);
      access(1, 0, 32'h5, 32'h0, 2'b00, 0, 0, 0);
      check("lb5_s0", rd0, 32'hFFFFFF98);
      check("lb5_s3", rd3, 32'hFFFFFF98);
      access(1, 0, 32'h5, 32'h0, 2'b00, 1, 0, 0);
      check("lb5_u0", rd0, 32'h00000098);
      access(1, 0, 32'h4, 32'h0, 2'b10, 0, 0, 0);
      check("lw4_0", rd0, 32'hABCD9800);
      check("lw4_3", rd3, 32'hABCD9800);
      access(1, 0, 32'h6, 32'h0, 2'b01, 0, 0, 0);
      check("lh6_s0", rd0, 32'hFFFFABCD);
      access(1, 0, 32'h6, 32'h0, 2'b01, 1, 0, 0);
      check("lh6_u0", rd0, 32'h0000ABCD);

      access(1, 0, 32'h2, 32'h0, 2'b10, 0, 0, 0);
      check("lw2_mis0", {31'h0, mis0}, 32'h1);
      check("lw2_data0", rd0, 32'h0);
      check("lw2_mis3", {31'h0, mis3}, 32'h1);
      access(1, 0, 32'h5, 32'h0, 2'b01, 0, 0, 0);
      check("lh5_mis0", {31'h0, mis0}, 32'h1);
      access(1, 0, 32'h4, 32'h0, 2'b11, 0, 0, 0);
      check("sz11_mis0", {31'h0, mis0}, 32'h1);
      access(0, 1, 32'h2, 32'h0, 2'b10, 0, 0, 0);
      check("sw2_mis0", {31'h0, mis0}, 32'h1);
      access(1, 0, 32'h0, 32'h0, 2'b10, 0, 0, 0);
      check("lw0_after_mis0", rd0, 32'h12345678);
      check("lw0_after_mis_ok0", {31'h0, mis0}, 32'h0);

      access(0, 1, 32'h8, 32'hFFFFFFFF, 2'b10, 0, 0, 0);
      access(1, 0, 32'h8, 32'h0, 2'b10, 0, 1, 0);
      check("ws3_lat3", lat3, 4);
      check("ws3_cnt3", cnt3, 1);
      check("ws3_data3", rd3, 32'hFFFFFFFF);

      access(0, 1, 32'hC, 32'h0BADF00D, 2'b10, 0, 0, 0);
      access(0, 1, 32'hC, 32'hDEADBEEF, 2'b10, 0, 0, 1);
      check("abort_cnt3", cnt3, 0);
      check("abort_cnt0", cnt0, 1);
      access(1, 0, 32'hC, 32'h0, 2'b10, 0, 0, 0);
      check("abort_old3", rd3, 32'h0BADF00D);
      check("abort_new0", rd0, 32'hDEADBEEF);

      access(1, 1, 32'h0, 32'h0, 2'b10, 0, 0, 0);
      check("both_cnt0", cnt0, 0);
      check("both_cnt3", cnt3, 0);
      access(0, 0, 32'h0, 32'h0, 2'b10, 0, 0, 0);
      check("none_cnt0", cnt0, 0);

      access(0, 1, 32'h40, 32'h11111111, 2'b10, 0, 0, 0);
      access(1, 0, 32'h0, 32'h0, 2'b10, 0, 0, 0);
      check("wrap0", rd0, 32'h11111111);
      check("nowrap3", rd3, 32'h12345678);

`ifdef DATA_MEMORY_SIZED_PARITY_EN
      u_dut0.u_array.r_par[1][0] = ~u_dut0.u_array.r_par[1][0];
      access(1, 0, 32'h4, 32'h0, 2'b00, 1, 0, 0);
      check("par_err0", {31'h0, pe0}, 32'h1);
      check("par_data0", rd0, 32'h00000000);
      access(1, 0, 32'h5, 32'h0, 2'b00, 1, 0, 0);
      check("par_ok0", {31'h0, pe0}, 32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
